// File: rtl/rv_pkg.sv
// Shared core constants: datapath width and register file addressing.
// Imported by writeback and register file blocks.
package rv_pkg;

  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with one-hot grant; owns the priority pointer.
// Ports: clk, rst_n, req[N], en -> gnt[N] (one-hot), gnt_idx.
module rr_arbiter #(
  parameter int N = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] idx;
  logic             found;
  int               j;

  // Scan ptr, ptr+1, ... wrapping; first valid wins.
  always_comb begin
    found = 1'b0;
    idx = ptr;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (en && found) gnt[idx] = 1'b1;
    gnt_idx = idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (idx == IDX_W'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among NUM_REQ writeback units.
// Ports: req_valid/req_ready/req_addr/req_data per unit, wb_block,
// wb_write_enable/addr/data to the register file, busy.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN = rv_pkg::XLEN,
  parameter int ADDR_W = rv_pkg::REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*XLEN-1:0]   req_data,
  input  logic                      wb_block,
  output logic                      wb_write_enable,
  output logic [ADDR_W-1:0]         wb_write_addr,
  output logic [XLEN-1:0]           wb_write_data,
  output logic                      busy
);

  import rv_pkg::*;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [ADDR_W-1:0]  sel_addr;
  logic [XLEN-1:0]    sel_data;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .en      (!wb_block),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign gnt_any = |gnt;
  assign req_ready = gnt & {NUM_REQ{rst_n}};
  assign busy = rst_n & |(req_valid & ~req_ready);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Writes to x0 are consumed but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_write_enable <= 1'b0;
      wb_write_addr <= '0;
      wb_write_data <= '0;
    end else if (gnt_any && sel_addr != ADDR_W'(REG_ZERO)) begin
      wb_write_enable <= 1'b1;
      wb_write_addr <= sel_addr;
      wb_write_data <= sel_data;
    end else begin
      wb_write_enable <= 1'b0;
    end
  end

endmodule
